// File: rtl/hex_disp_pkg.sv
// ----------------------------------------------------------------------------
// hex_disp_pkg
//   Shared definitions for the multiplexed 7-segment display blocks:
//   active-low segment codes for hex digits 0..F ({dp,g,f,e,d,c,b,a}),
//   blank patterns, the scroll FSM state type and an anode-select helper.
// ----------------------------------------------------------------------------
package hex_disp_pkg;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } state_t;

    // Active-low one-hot anode pattern for a digit index (digit 0 = rightmost).
    function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// ----------------------------------------------------------------------------
// hex_seg_lut
//   Combinational hex nibble to active-low 7-segment pattern (dp kept off).
//   Ports:
//     nib  in  4  hex value 0..F
//     seg  out 8  {dp,g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module hex_seg_lut
    import hex_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// ----------------------------------------------------------------------------
// hex_scroll_ctrl
//   Scrolling sequencer for a 4-digit multiplexed 7-segment display. Holds an
//   8-nibble message, shows a 4-digit window starting at 'offset' and shifts
//   the window at the scroll rate. A one-entry shadow buffer queues the next
//   message, which is swapped in only when the offset wraps 7 -> 0.
//
//   Optional build macro HEX_SCROLL_PWM_EN: anode on-time within each digit
//   slot is limited to ((brightness+1)*SCAN_DIV)>>4 scan cycles. Without the
//   macro the anode is on for the whole slot and brightness is ignored.
//
//   Ports:
//     mclk        in   1   system clock
//     rst_n       in   1   asynchronous active-low reset
//     load_valid  in   1   producer offers a message
//     load_data   in  32   message, nibble i = load_data[4i+3:4i]
//     load_ready  out  1   message can be accepted this cycle
//     run         in   1   1 = scroll, 0 = freeze offset
//     clear       in   1   return to IDLE, drop pending message
//     brightness  in   4   PWM duty (HEX_SCROLL_PWM_EN builds only)
//     D0_a        out  4   anodes, active-low, bit k = digit k
//     D0_seg      out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
//     busy        out  1   high while scrolling
// ----------------------------------------------------------------------------
module hex_scroll_ctrl
    import hex_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int SCROLL_DIV = 50000000,
    parameter int CNT_W      = 27
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        run,
    input  logic        clear,
    input  logic [3:0]  brightness,
    output logic [3:0]  D0_a,
    output logic [7:0]  D0_seg,
    output logic        busy
);

    localparam logic [CNT_W-1:0] SCAN_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SCROLL_LAST = CNT_W'(SCROLL_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [CNT_W-1:0]  scroll_cnt_q, scroll_cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [2:0]        offset_q, offset_d;
    logic [31:0]       active_q, active_d;
    logic [31:0]       shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic              scan_tick;
    logic              scroll_tick;
    logic              accept;
    logic [2:0]        nib_idx;
    logic [3:0]        nib_next;
    logic [7:0]        seg_next;

    // clear wins over a simultaneous load, so the producer must never see
    // ready while clear is high.
    assign load_ready = ~clear & ((state_q == IDLE) | ~pending_q);
    assign accept     = load_valid & load_ready;
    assign busy       = (state_q == SCROLL);

    assign scan_tick   = (scan_cnt_q == SCAN_LAST);
    assign scroll_tick = (state_q == SCROLL) & run & (scroll_cnt_q == SCROLL_LAST);

    // Segment pattern is looked up from the post-edge window so the registered
    // outputs always match the committed offset/message.
    assign nib_idx  = offset_d + {1'b0, digit_d};
    assign nib_next = active_d[{nib_idx, 2'b00} +: 4];

    hex_seg_lut u_lut (
        .nib (nib_next),
        .seg (seg_next)
    );

    always_comb begin
        state_d      = state_q;
        scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + CNT_ONE;
        digit_d      = scan_tick ? digit_q + 2'd1 : digit_q;
        scroll_cnt_d = scroll_cnt_q;
        offset_d     = offset_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        an_d         = an_q;
        seg_d        = seg_q;

        case (state_q)
            IDLE: begin
                pending_d = 1'b0;
                if (accept) begin
                    active_d     = load_data;
                    offset_d     = 3'd0;
                    scroll_cnt_d = '0;
                    state_d      = SCROLL;
                end
            end
            SCROLL: begin
                if (clear) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else begin
                    if (run) begin
                        scroll_cnt_d = scroll_tick ? '0 : scroll_cnt_q + CNT_ONE;
                    end
                    if (scroll_tick) begin
                        offset_d = offset_q + 3'd1;
                        // Swap only a message queued before this cycle; a load
                        // accepted on the wrap itself waits for the next wrap.
                        if (offset_q == 3'd7 && pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end
                    end
                    if (accept) begin
                        shadow_d  = load_data;
                        pending_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end else if (scan_tick) begin
            an_d  = an_onehot_low(digit_d);
            seg_d = seg_next;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            scan_cnt_q   <= '0;
            scroll_cnt_q <= '0;
            digit_q      <= 2'd0;
            offset_q     <= 3'd0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            scan_cnt_q   <= scan_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
            digit_q      <= digit_d;
            offset_q     <= offset_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign D0_seg = seg_q;

`ifdef HEX_SCROLL_PWM_EN
    localparam int PW = CNT_W + 5;

    logic [3:0]    brightness_q, brightness_d;
    logic [PW-1:0] pwm_lim;

    assign brightness_d = scan_tick ? brightness : brightness_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            brightness_q <= 4'd0;
        end else begin
            brightness_q <= brightness_d;
        end
    end

    // On-window length in scan cycles for the current slot.
    assign pwm_lim = ((PW'(brightness_q) + PW'(1)) * PW'(SCAN_DIV)) >> 4;
    assign D0_a    = (PW'(scan_cnt_q) < pwm_lim) ? an_q : AN_OFF;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign D0_a              = an_q;
`endif

endmodule
